// File: rtl/cla_pkg.sv
// Shared constants and the per-stage pipeline record for the pipelined
// carry-look-ahead adder/subtractor.
package cla_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_BLK   = 4;
    localparam int MAX_W     = 64;

    // Fields are sized for the widest legal operand; narrower instances
    // leave the upper bits at zero.
    typedef struct packed {
        logic             valid;
        logic             carry;
        logic [MAX_W-1:0] psum;
        logic [MAX_W-1:0] rem_a;
        logic [MAX_W-1:0] rem_bx;
        logic             a_msb;
        logic             bx_msb;
    } stage_t;

endpackage

// File: rtl/cla_block.sv
// Combinational BLK-bit carry-look-ahead block with group propagate/generate.
module cla_block #(
    parameter int BLK = 4
) (
    input  logic [BLK-1:0] x,
    input  logic [BLK-1:0] y,
    input  logic           c_in,
    output logic [BLK-1:0] s,
    output logic           c_out,
    output logic           p,
    output logic           g
);

    logic [BLK-1:0] pv;
    logic [BLK-1:0] gv;
    logic [BLK:0]   c;
    logic           gg;
    logic           pp;

    assign pv = x ^ y;
    assign gv = x & y;

    // Every carry is formed directly from c_in and the prefix P/G terms.
    always_comb begin
        c    = '0;
        c[0] = c_in;
        gg   = 1'b0;
        pp   = 1'b1;
        for (int i = 0; i < BLK; i++) begin
            gg       = gv[i] | (pv[i] & gg);
            pp       = pp & pv[i];
            c[i+1]   = gg | (pp & c_in);
        end
    end

    assign s     = pv ^ c[BLK-1:0];
    assign c_out = c[BLK];
    assign p     = pp;
    assign g     = gg;

endmodule

// File: rtl/cla_pipe_addsub.sv
// Pipelined add/subtract: one BLK-bit look-ahead block per stage, operands
// and partial sums skewed through the stage registers.
module cla_pipe_addsub
    import cla_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int BLK   = DEF_BLK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = WIDTH / BLK;

    // Handshake: a word moves on a rising edge where valid && ready. The whole
    // pipe advances together whenever the output slot is empty or being taken,
    // so in_ready depends only on the output side and never on in_valid.
    logic adv;

    logic [WIDTH-1:0] bx;
    logic             ce;
    stage_t           in_st;
    stage_t           pipe [0:STAGES];
    stage_t           nxt  [0:STAGES-1];

    logic [BLK-1:0]   blk_s [0:STAGES-1];
    logic             blk_c [0:STAGES-1];
    logic             blk_p [0:STAGES-1];
    logic             blk_g [0:STAGES-1];

    assign adv      = !pipe[STAGES].valid || out_ready;
    assign in_ready = adv;

    assign bx = sub ? ~b : b;
    assign ce = sub ? 1'b1 : cin;

    always_comb begin
        in_st        = '0;
        in_st.valid  = in_valid;
        in_st.carry  = ce;
        in_st.rem_a  = MAX_W'(a);
        in_st.rem_bx = MAX_W'(bx);
        in_st.a_msb  = a[WIDTH-1];
        in_st.bx_msb = bx[WIDTH-1];
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        cla_block #(.BLK(BLK)) u_blk (
            .x    (pipe[k].rem_a[BLK-1:0]),
            .y    (pipe[k].rem_bx[BLK-1:0]),
            .c_in (pipe[k].carry),
            .s    (blk_s[k]),
            .c_out(blk_c[k]),
            .p    (blk_p[k]),
            .g    (blk_g[k])
        );
    end

    // Stage k consumes the low BLK bits of the remaining operands and deposits
    // its sum slice at bit k*BLK of the partial sum.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            nxt[k]        = pipe[k];
            nxt[k].carry  = blk_c[k];
            nxt[k].psum   = pipe[k].psum | (MAX_W'(blk_s[k]) << (k * BLK));
            nxt[k].rem_a  = pipe[k].rem_a >> BLK;
            nxt[k].rem_bx = pipe[k].rem_bx >> BLK;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= STAGES; i++) begin
                pipe[i] <= '0;
            end
        end else if (adv) begin
            pipe[0] <= in_st;
            for (int k = 0; k < STAGES; k++) begin
                pipe[k+1] <= nxt[k];
            end
        end
    end

    assign out_valid = pipe[STAGES].valid;
    assign sum       = out_valid ? pipe[STAGES].psum[WIDTH-1:0] : '0;
    assign cout      = out_valid & pipe[STAGES].carry;
    assign ovf       = out_valid & (pipe[STAGES].a_msb == pipe[STAGES].bx_msb)
                     & (pipe[STAGES].psum[WIDTH-1] != pipe[STAGES].a_msb);

    logic unused_pg;
    assign unused_pg = blk_p[0] ^ blk_g[0];

endmodule
